// File: rtl/alu_result_monitor.sv
// Monitor for the time-multiplexed ALU output stream: follows the op rotation,
// captures each settled slot result into a 6-entry bank and checks it against a local model.
module alu_result_monitor #(
    parameter int SETTLE_CYC = 4,
    parameter int ERR_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [7:0]       alu_result,
    input  logic [7:0]       a_in,
    input  logic [7:0]       b_in,
    input  logic             slot_tick,
    input  logic [2:0]       rd_sel,
    output logic [7:0]       rd_data,
    output logic             rd_valid,
    output logic [2:0]       cur_op,
    output logic             frame_done,
    output logic             missed,
    output logic             err_flag,
    output logic [ERR_W-1:0] err_count
);

    localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

    typedef enum logic [1:0] {
        ST_SETTLE  = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_HOLD    = 2'd2
    } state_t;

    function automatic logic [7:0] expected_result(input logic [2:0] op,
                                                   input logic [7:0] a,
                                                   input logic [7:0] b);
        logic [7:0] r;
        case (op)
            3'd0:    r = a + b;
            3'd1:    r = a - b;
            3'd2:    r = a & b;
            3'd3:    r = a | b;
            3'd4:    r = {a[6:0], 1'b0};
            3'd5:    r = {1'b0, a[7:1]};
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [2:0]       cur_op_r;
    logic [7:0]       bank_r [0:5];
    logic [5:0]       valid_r;
    logic [7:0]       rd_data_r;
    logic             rd_valid_r;
    logic             frame_done_r;
    logic             missed_r;
    logic             err_flag_r;
    logic [ERR_W-1:0] err_count_r;

    logic [2:0]       next_op_s;
    logic [7:0]       exp_s;
    logic             mismatch_s;

    // Next op in the 0..5 rotation and the model result for the current slot
    always_comb begin
        if (cur_op_r == 3'd5) begin
            next_op_s = 3'd0;
        end else begin
            next_op_s = cur_op_r + 3'd1;
        end
        exp_s      = expected_result(cur_op_r, a_in, b_in);
        mismatch_s = (alu_result != exp_s);
    end

    // Slot sequencer, capture bank and error tracking; ena low freezes everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_SETTLE;
            cnt_r        <= {CNT_W{1'b0}};
            cur_op_r     <= 3'd0;
            valid_r      <= 6'd0;
            frame_done_r <= 1'b0;
            missed_r     <= 1'b0;
            err_flag_r   <= 1'b0;
            err_count_r  <= {ERR_W{1'b0}};
            for (int i = 0; i < 6; i++) begin
                bank_r[i] <= 8'h00;
            end
        end else if (ena) begin
            frame_done_r <= 1'b0;
            // Capture finishes for the old op even when a tick lands on it
            if ((state_r == ST_CAPTURE) && (cur_op_r <= 3'd5)) begin
                bank_r[cur_op_r]  <= alu_result;
                valid_r[cur_op_r] <= 1'b1;
                frame_done_r      <= (cur_op_r == 3'd5);
                if (mismatch_s) begin
                    err_flag_r <= 1'b1;
                    if (err_count_r != ERR_MAX) begin
                        err_count_r <= err_count_r + ERR_W'(1);
                    end
                end
            end
            if (slot_tick) begin
                cur_op_r <= next_op_s;
                state_r  <= ST_SETTLE;
                cnt_r    <= {CNT_W{1'b0}};
                if (state_r == ST_SETTLE) begin
                    missed_r <= 1'b1;
                end
            end else begin
                case (state_r)
                    ST_SETTLE: begin
                        if (cnt_r == CNT_LAST) begin
                            state_r <= ST_CAPTURE;
                            cnt_r   <= {CNT_W{1'b0}};
                        end else begin
                            cnt_r <= cnt_r + CNT_W'(1);
                        end
                    end
                    ST_CAPTURE: state_r <= ST_HOLD;
                    ST_HOLD:    state_r <= ST_HOLD;
                    default: begin
                        state_r <= ST_SETTLE;
                        cnt_r   <= {CNT_W{1'b0}};
                    end
                endcase
            end
        end
    end

    // Registered read port, live regardless of ena; a same-cycle write is not forwarded
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_r  <= 8'h00;
            rd_valid_r <= 1'b0;
        end else if (rd_sel <= 3'd5) begin
            rd_data_r  <= bank_r[rd_sel];
            rd_valid_r <= valid_r[rd_sel];
        end else begin
            rd_data_r  <= 8'h00;
            rd_valid_r <= 1'b0;
        end
    end

    assign rd_data    = rd_data_r;
    assign rd_valid   = rd_valid_r;
    assign cur_op     = cur_op_r;
    assign frame_done = frame_done_r;
    assign missed     = missed_r;
    assign err_flag   = err_flag_r;
    assign err_count  = err_count_r;

endmodule

// File: tb/tb_alu_result_monitor.sv
// Directed bench for alu_result_monitor: drives an ALU model in step with slot_tick
// and checks bank contents, frame pulses, missed/error flags, ena freeze and reset.
module tb_alu_result_monitor;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] alu_result;
    logic [7:0] a_in;
    logic [7:0] b_in;
    logic       slot_tick;
    logic [2:0] rd_sel;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic [2:0] cur_op;
    logic       frame_done;
    logic       missed;
    logic       err_flag;
    logic [7:0] err_count;

    int checks   = 0;
    int failures = 0;

    logic [2:0] tb_op;
    logic       corrupt_op2;
    logic       corrupt_all;

    alu_result_monitor #(.SETTLE_CYC(4), .ERR_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .alu_result(alu_result),
        .a_in(a_in), .b_in(b_in), .slot_tick(slot_tick), .rd_sel(rd_sel),
        .rd_data(rd_data), .rd_valid(rd_valid), .cur_op(cur_op),
        .frame_done(frame_done), .missed(missed), .err_flag(err_flag),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a << 1;
            3'd5:    return a >> 1;
            default: return 8'h00;
        endcase
    endfunction

    always_comb begin
        if (corrupt_all || (corrupt_op2 && tb_op == 3'd2)) alu_result = 8'hFF;
        else alu_result = alu_model(tb_op, a_in, b_in);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tick();
        slot_tick = 1'b1;
        step(1);
        slot_tick = 1'b0;
        if (ena) tb_op = (tb_op == 3'd5) ? 3'd0 : tb_op + 3'd1;
    endtask

    // Full slot: settle + capture + one hold cycle, then the tick
    task automatic slot();
        step(5);
        chk("frame_done", {31'd0, frame_done}, {31'd0, (ena && tb_op == 3'd5)});
        chk("cur_op", {29'd0, cur_op}, {29'd0, tb_op});
        tick();
    endtask

    task automatic rd(input logic [2:0] sel, input logic [7:0] exp_d, input logic exp_v);
        rd_sel = sel;
        step(1);
        chk("rd_data", {24'd0, rd_data}, {24'd0, exp_d});
        chk("rd_valid", {31'd0, rd_valid}, {31'd0, exp_v});
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_rd_data"}, {24'd0, rd_data}, 32'd0);
        chk({tag, "_rd_valid"}, {31'd0, rd_valid}, 32'd0);
        chk({tag, "_cur_op"}, {29'd0, cur_op}, 32'd0);
        chk({tag, "_frame_done"}, {31'd0, frame_done}, 32'd0);
        chk({tag, "_missed"}, {31'd0, missed}, 32'd0);
        chk({tag, "_err_flag"}, {31'd0, err_flag}, 32'd0);
        chk({tag, "_err_count"}, {24'd0, err_count}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b1; slot_tick = 1'b0; rd_sel = 3'd0;
        a_in = 8'h0F; b_in = 8'h01; tb_op = 3'd0;
        corrupt_op2 = 1'b0; corrupt_all = 1'b0;
        step(3);
        chk_zero("reset");
        rst_n = 1'b1;

        // Clean rotation
        repeat (6) slot();
        rd(3'd0, 8'h10, 1'b1); rd(3'd1, 8'h0E, 1'b1); rd(3'd2, 8'h01, 1'b1);
        rd(3'd3, 8'h0F, 1'b1); rd(3'd4, 8'h1E, 1'b1); rd(3'd5, 8'h07, 1'b1);
        chk("clean_err_flag", {31'd0, err_flag}, 32'd0);
        chk("clean_err_count", {24'd0, err_count}, 32'd0);
        chk("clean_missed", {31'd0, missed}, 32'd0);

        // Op 2 result corrupted
        corrupt_op2 = 1'b1;
        repeat (6) slot();
        corrupt_op2 = 1'b0;
        chk("corrupt_err_flag", {31'd0, err_flag}, 32'd1);
        chk("corrupt_err_count", {24'd0, err_count}, 32'd1);
        rd(3'd2, 8'hFF, 1'b1);
        rd(3'd3, 8'h0F, 1'b1);

        // ena low across three ticks: nothing moves, reads still work
        ena = 1'b0; corrupt_all = 1'b1;
        repeat (3) slot();
        chk("frozen_cur_op", {29'd0, cur_op}, 32'd0);
        chk("frozen_err_count", {24'd0, err_count}, 32'd1);
        chk("frozen_missed", {31'd0, missed}, 32'd0);
        rd(3'd2, 8'hFF, 1'b1);
        rd(3'd0, 8'h10, 1'b1);
        ena = 1'b1; corrupt_all = 1'b0;
        repeat (6) slot();
        chk("resume_err_count", {24'd0, err_count}, 32'd1);
        chk("resume_missed", {31'd0, missed}, 32'd0);
        rd(3'd2, 8'h01, 1'b1);

        // Saturation of the error counter
        corrupt_all = 1'b1;
        repeat (254) slot();
        chk("sat_reach", {24'd0, err_count}, 32'd255);
        repeat (46) slot();
        chk("sat_hold", {24'd0, err_count}, 32'd255);
        chk("sat_err_flag", {31'd0, err_flag}, 32'd1);
        corrupt_all = 1'b0;

        // Async reset in the middle of op 3 settle
        repeat (3) slot();
        step(2);
        chk("pre_reset_cur_op", {29'd0, cur_op}, 32'd3);
        rst_n = 1'b0;
        #1;
        chk_zero("async_reset");
        tb_op = 3'd0;
        step(2);
        rst_n = 1'b1;

        // Early tick during op 1 settle
        slot();
        step(2);
        tick();
        chk("missed_set", {31'd0, missed}, 32'd1);
        chk("missed_cur_op", {29'd0, cur_op}, 32'd2);
        repeat (4) slot();
        rd(3'd1, 8'h00, 1'b0);
        rd(3'd0, 8'h10, 1'b1);
        rd(3'd5, 8'h07, 1'b1);
        rd(3'd6, 8'h00, 1'b0);
        rd(3'd7, 8'h00, 1'b0);
        chk("final_missed", {31'd0, missed}, 32'd1);
        chk("final_err_count", {24'd0, err_count}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
